// File: rtl/mux_rr_arbiter.sv
// Two-channel round-robin arbiter feeding a one-entry output register.
// The registered sel records which channel the held word came from.
module mux_rr_arbiter #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 16,
  parameter bit START_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   pri;
  logic   load_en;
  logic   grant_a;
  logic   grant_b;
  logic   accept;

  assign out_valid = (state_q == FULL);
  assign load_en   = ~out_valid | out_ready;

  // pri names the channel that wins when both request; a lone requester always wins.
  assign grant_a = a_valid & (~b_valid | ~pri);
  assign grant_b = b_valid & (~a_valid | pri);

  assign a_ready = rst_n & load_en & grant_a;
  assign b_ready = rst_n & load_en & grant_b;
  assign accept  = a_ready | b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A new accept always refills, which also covers drain-and-refill on one edge.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      sel        <= 1'b0;
      pri        <= START_PRIO;
      xfer_count <= '0;
    end else if (accept) begin
      out_data   <= b_ready ? b_data : a_data;
      sel        <= b_ready;
      pri        <= ~b_ready;
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed vectors push expected words,
// per-instance monitors pop and compare on every output handshake.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic       out_ready;

  logic       a0_valid, b0_valid, a0_ready, b0_ready, out0_valid, sel0;
  logic [7:0] out0_data;
  logic [3:0] xfer0;

  logic        a1_valid, b1_valid, a1_ready, b1_ready, out1_valid, sel1;
  logic [7:0]  out1_data;
  logic [15:0] xfer1;

  int compared = 0;
  int failed   = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [3:0]  expCount0 = '0;
  logic [15:0] expCount1 = '0;

  mux_rr_arbiter #(.WIDTH(8), .CNT_W(4), .START_PRIO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a0_valid), .a_data(a_data), .a_ready(a0_ready),
    .b_valid(b0_valid), .b_data(b_data), .b_ready(b0_ready),
    .out_valid(out0_valid), .out_data(out0_data), .out_ready(out_ready),
    .sel(sel0), .xfer_count(xfer0)
  );

  mux_rr_arbiter #(.WIDTH(8), .CNT_W(16), .START_PRIO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a1_valid), .a_data(a_data), .a_ready(a1_ready),
    .b_valid(b1_valid), .b_data(b_data), .b_ready(b1_ready),
    .out_valid(out1_valid), .out_data(out1_data), .out_ready(out_ready),
    .sel(sel1), .xfer_count(xfer1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle on instance d; expected readies are hand-computed by the caller.
  task automatic applyStimulus(input bit d, input bit av, input logic [7:0] ad,
                               input bit bv, input logic [7:0] bd, input bit ordy,
                               input bit expAr, input bit expBr);
    a_data    = ad;
    b_data    = bd;
    out_ready = ordy;
    a0_valid  = d ? 1'b0 : av;
    b0_valid  = d ? 1'b0 : bv;
    a1_valid  = d ? av : 1'b0;
    b1_valid  = d ? bv : 1'b0;
    @(negedge clk);
    if (!d) begin
      checkOutput("a0_ready", 32'(a0_ready), 32'(expAr));
      checkOutput("b0_ready", 32'(b0_ready), 32'(expBr));
      if (expAr) q0.push_back({1'b0, ad});
      if (expBr) q0.push_back({1'b1, bd});
      if (expAr | expBr) expCount0 = expCount0 + 4'd1;
    end else begin
      checkOutput("a1_ready", 32'(a1_ready), 32'(expAr));
      checkOutput("b1_ready", 32'(b1_ready), 32'(expBr));
      if (expAr) q1.push_back({1'b0, ad});
      if (expBr) q1.push_back({1'b1, bd});
      if (expAr | expBr) expCount1 = expCount1 + 16'd1;
    end
    @(posedge clk);
    #1;
    if (!d) checkOutput("xfer0", 32'(xfer0), 32'(expCount0));
    else    checkOutput("xfer1", 32'(xfer1), 32'(expCount1));
  endtask

  // Monitors consume the scoreboard whenever a word leaves an output register.
  always @(negedge clk) begin
    if (rst_n && out0_valid && out_ready) begin
      if (q0.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL out0_unexpected: got %0h with empty scoreboard", out0_data);
      end else begin
        logic [8:0] e;
        e = q0.pop_front();
        checkOutput("out0_data", 32'(out0_data), 32'(e[7:0]));
        checkOutput("out0_sel", 32'(sel0), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out1_valid && out_ready) begin
      if (q1.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL out1_unexpected: got %0h with empty scoreboard", out1_data);
      end else begin
        logic [8:0] e;
        e = q1.pop_front();
        checkOutput("out1_data", 32'(out1_data), 32'(e[7:0]));
        checkOutput("out1_sel", 32'(sel1), 32'(e[8]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_data = 8'h00; b_data = 8'h00; out_ready = 1'b0;
    a0_valid = 1'b1; b0_valid = 1'b1; a1_valid = 1'b0; b1_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(out0_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out0_data), 32'd0);
    checkOutput("rst_sel", 32'(sel0), 32'd0);
    checkOutput("rst_xfer", 32'(xfer0), 32'd0);
    checkOutput("rst_a_ready", 32'(a0_ready), 32'd0);
    checkOutput("rst_b_ready", 32'(b0_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] alternating AA/BB");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, (i % 2) == 0, (i % 2) == 1);

    $display("[TB] lone requesters");
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("lone_out_valid", 32'(out0_valid), 32'd1);
    checkOutput("lone_out_data", 32'(out0_data), 32'h11);
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1);

    $display("[TB] backpressure hold");
    applyStimulus(1'b0, 1'b1, 8'h5C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h66, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      checkOutput("hold_data", 32'(out0_data), 32'h5C);
      checkOutput("hold_sel", 32'(sel0), 32'd0);
      checkOutput("hold_valid", 32'(out0_valid), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 8'h66, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    checkOutput("refill_data", 32'(out0_data), 32'h77);
    checkOutput("refill_sel", 32'(sel0), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_valid", 32'(out0_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h88, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] counter wrap");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, 8'h90 + 8'(i), 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_xfer", 32'(xfer0), 32'd0);

    $display("[TB] async reset mid-stream");
    #2;
    a0_valid = 1'b1;
    b0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out0_valid), 32'd0);
    checkOutput("mid_rst_sel", 32'(sel0), 32'd0);
    checkOutput("mid_rst_xfer", 32'(xfer0), 32'd0);
    checkOutput("mid_rst_a_ready", 32'(a0_ready), 32'd0);
    checkOutput("mid_rst_b_ready", 32'(b0_ready), 32'd0);
    q0.delete();
    q1.delete();
    expCount0 = '0;
    expCount1 = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1);

    $display("[TB] B-first instance");
    applyStimulus(1'b1, 1'b1, 8'hC1, 1'b1, 8'hD1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hE1, 1'b1, 8'hF1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    checkOutput("q0_drained", 32'(q0.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
